// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder with carry-in. The operands are split into STAGES chunks of
//   CW = WIDTH/STAGES bits. One chunk is added per clock, and the carry is
//   registered between chunks. Lower result chunks move down the pipe next to
//   the chunk still being added, so every result comes out deskewed.
//   The whole pipe advances as one unit. It holds every register, including
//   the valid bits, while a finished result waits for the consumer.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth (= latency in cycles), 1..WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears valid bits and result registers
//   in_valid   a/b/cin present this cycle
//   in_ready   pipe can take a/b/cin this cycle
//   a, b, cin  operands and carry-in into bit 0
//   out_valid  sum/carry (and overflow) hold a result
//   out_ready  consumer takes the result this cycle
//   sum        (a + b + cin) mod 2^WIDTH
//   carry      carry out of bit WIDTH-1
//   overflow   signed overflow; present only when PIPE_ADDER_OVF_EN is defined
//
// Optional feature macro: PIPE_ADDER_OVF_EN
//   Defining it pipelines the operand sign bits to the last stage and adds the
//   overflow output. Without it, neither the port nor the sign registers exist.

module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
   end

   logic              advance_s;
   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   // Operands carried alongside each stage; stage k reads chunk k of stage k-1's copy
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opa_d [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic [WIDTH-1:0]  opb_d [STAGES];
   logic [CW:0]       chunk_s [STAGES];

   // Global advance: the pipe moves unless a finished result is being held back
   always_comb begin
      advance_s = ~valid_q[LAST] | out_ready;
   end

   assign in_ready  = advance_s;
   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign carry     = carry_q[LAST];

   // Per-stage next state: chunk add, carry hand-off, deskewed result and operand transport
   always_comb begin
      chunk_s[0]       = {1'b0, a[CW-1:0]} + {1'b0, b[CW-1:0]} + {{CW{1'b0}}, cin};
      valid_d[0]       = in_valid;
      carry_d[0]       = chunk_s[0][CW];
      sum_d[0]         = {WIDTH{1'b0}};
      sum_d[0][CW-1:0] = chunk_s[0][CW-1:0];
      opa_d[0]         = a;
      opb_d[0]         = b;
      for (int k = 1; k < STAGES; k++) begin
         chunk_s[k] = {1'b0, opa_q[k-1][k*CW +: CW]}
                    + {1'b0, opb_q[k-1][k*CW +: CW]}
                    + {{CW{1'b0}}, carry_q[k-1]};
         valid_d[k] = valid_q[k-1];
         carry_d[k] = chunk_s[k][CW];
         // Lower chunks are already final; only chunk k is filled in here
         sum_d[k]               = sum_q[k-1];
         sum_d[k][k*CW +: CW]   = chunk_s[k][CW-1:0];
         opa_d[k]               = opa_q[k-1];
         opb_d[k]               = opb_q[k-1];
      end
   end

   // Stage registers: cleared by reset, loaded together on advance, otherwise held
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= {STAGES{1'b0}};
         carry_q <= {STAGES{1'b0}};
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= {WIDTH{1'b0}};
            opa_q[k] <= {WIDTH{1'b0}};
            opb_q[k] <= {WIDTH{1'b0}};
         end
      end else if (advance_s) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k] <= sum_d[k];
            opa_q[k] <= opa_d[k];
            opb_q[k] <= opb_d[k];
         end
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   logic [STAGES-1:0] sgn_a_q, sgn_a_d;
   logic [STAGES-1:0] sgn_b_q, sgn_b_d;

   // Signed overflow: operands agree in sign but the result sign differs
   function automatic logic ovf_f(input logic sa, input logic sb, input logic sr);
      return (sa == sb) & (sr != sa);
   endfunction

   // Sign-bit transport down to the last stage
   always_comb begin
      sgn_a_d[0] = a[WIDTH-1];
      sgn_b_d[0] = b[WIDTH-1];
      for (int k = 1; k < STAGES; k++) begin
         sgn_a_d[k] = sgn_a_q[k-1];
         sgn_b_d[k] = sgn_b_q[k-1];
      end
   end

   // Sign-bit registers move with the rest of the pipe
   always_ff @(posedge clk) begin
      if (reset) begin
         sgn_a_q <= {STAGES{1'b0}};
         sgn_b_q <= {STAGES{1'b0}};
      end else if (advance_s) begin
         sgn_a_q <= sgn_a_d;
         sgn_b_q <= sgn_b_d;
      end
   end

   // Built only from registered state, so it is stable with sum and reads 0 after reset
   assign overflow = ovf_f(sgn_a_q[LAST], sgn_b_q[LAST], sum_q[LAST][WIDTH-1]);
`endif

endmodule
